// File: rtl/div_pkg.sv
// Shared definitions for the iterative divide sequencer: op encodings, FSM states
// and fixed constants.
package div_pkg;

    localparam int XLEN        = 32;
    localparam int ITER_N      = 32;
    localparam int DIV_LATENCY = 37;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE   = 32'hFFFF_FFFF;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_NEG_A = 3'd1,
        ST_NEG_B = 3'd2,
        ST_ITER  = 3'd3,
        ST_NEG_Q = 3'd4,
        ST_NEG_R = 3'd5,
        ST_DONE  = 3'd6
    } div_state_e;

    // Bit 0 of the op encoding selects the unsigned variant.
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    // Bit 1 of the op encoding selects the remainder as the result.
    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/add_sub32.sv
// 32-bit adder/subtractor, modulo 2^32: out = sub ? a - b : a + b.
module add_sub32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] out
);

    assign out = a + (b ^ {32{sub}}) + {31'd0, sub};

endmodule

// File: rtl/div_seq32.sv
// Iterative RISC-V DIV/DIVU/REM/REMU unit: one shared add_sub32 performs operand
// negation, 32 restoring-division steps and the final sign fix-up.
module div_seq32
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);

    div_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] r_q, r_d;
    logic [31:0] q_q, q_d;
    logic [31:0] result_q, result_d;
    logic [1:0]  op_q, op_d;
    logic        sa_q, sa_d;
    logic        sb_q, sb_d;

    logic [31:0] add_a_s, add_b_s, add_out_s;
    logic        add_sub_s;
    logic [31:0] r_sh_s, q_sh_s;
    logic        msb_s, borrow_s;
    logic        div0_s, ovf_s;

    add_sub32 u_add_sub32 (
        .a   (add_a_s),
        .b   (add_b_s),
        .sub (add_sub_s),
        .out (add_out_s)
    );

    assign r_sh_s = {r_q[30:0], q_q[31]};
    assign q_sh_s = {q_q[30:0], 1'b0};
    assign msb_s  = r_q[31];
    // With the shifted-out msb set, the 33-bit partial remainder always exceeds B.
    assign borrow_s = ~msb_s & ((r_sh_s[31] ^ b_q[31]) ? ~r_sh_s[31] : add_out_s[31]);

    assign div0_s = (divisor == 32'd0);
    assign ovf_s  = op_is_signed(op) & (dividend == INT_MIN) & (divisor == NEG_ONE);

    // Operand mux for the shared adder; parked at zero when idle or done.
    always_comb begin
        add_a_s   = 32'd0;
        add_b_s   = 32'd0;
        add_sub_s = 1'b0;
        case (state_q)
            ST_NEG_A: begin add_b_s = a_q; add_sub_s = 1'b1; end
            ST_NEG_B: begin add_b_s = b_q; add_sub_s = 1'b1; end
            ST_ITER:  begin add_a_s = r_sh_s; add_b_s = b_q; add_sub_s = 1'b1; end
            ST_NEG_Q: begin add_b_s = q_q; add_sub_s = 1'b1; end
            ST_NEG_R: begin add_b_s = r_q; add_sub_s = 1'b1; end
            default:  begin add_a_s = 32'd0; add_b_s = 32'd0; add_sub_s = 1'b0; end
        endcase
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        q_d      = q_q;
        result_d = result_q;
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;

        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = 5'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_d = op;
                        a_d  = dividend;
                        b_d  = divisor;
                        sa_d = op_is_signed(op) & dividend[31];
                        sb_d = op_is_signed(op) & divisor[31];
                        cnt_d = 5'd0;
                        if (div0_s) begin
                            result_d = op_is_rem(op) ? dividend : DIV0_QUOT;
                            state_d  = ST_DONE;
                        end else if (ovf_s) begin
                            result_d = op_is_rem(op) ? 32'd0 : INT_MIN;
                            state_d  = ST_DONE;
                        end else begin
                            state_d = ST_NEG_A;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_NEG_A: begin
                    a_d     = sa_q ? add_out_s : a_q;
                    state_d = ST_NEG_B;
                end
                ST_NEG_B: begin
                    b_d     = sb_q ? add_out_s : b_q;
                    r_d     = 32'd0;
                    q_d     = a_q;
                    state_d = ST_ITER;
                end
                ST_ITER: begin
                    if (borrow_s) begin
                        r_d = r_sh_s;
                        q_d = q_sh_s;
                    end else begin
                        r_d = add_out_s;
                        q_d = {q_sh_s[31:1], 1'b1};
                    end
                    if (cnt_q == 5'(ITER_N - 1)) begin
                        cnt_d   = 5'd0;
                        state_d = ST_NEG_Q;
                    end else begin
                        cnt_d   = cnt_q + 5'd1;
                        state_d = ST_ITER;
                    end
                end
                ST_NEG_Q: begin
                    q_d     = (sa_q ^ sb_q) ? add_out_s : q_q;
                    state_d = ST_NEG_R;
                end
                ST_NEG_R: begin
                    r_d      = sa_q ? add_out_s : r_q;
                    result_d = op_is_rem(op_q) ? (sa_q ? add_out_s : r_q) : q_q;
                    state_d  = ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 5'd0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 5'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            r_q      <= 32'd0;
            q_q      <= 32'd0;
            result_q <= 32'd0;
            op_q     <= 2'd0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            q_q      <= q_d;
            result_q <= result_d;
            op_q     <= op_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;

endmodule

// File: tb/tb_div_seq32.sv
// Directed-vector bench for div_seq32: table of ops with expected result and latency,
// plus hand-written flush, back-pressure and reset sequences.
module tb_div_seq32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    always #5 clk = ~clk;

    div_seq32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one op at a negedge, then wait (bounded) for out_valid; lat=-1 on timeout.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        @(negedge clk);
        chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        op = o; dividend = a; divisor = b; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = -1;
        res = 32'hDEAD_BEEF;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = n;
                res = result;
                break;
            end
        end
    endtask

    initial begin
        automatic logic [31:0] res;
        automatic int lat;
        automatic int bad;

        vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         37};
        vecs[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          37};
        vecs[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  37};
        vecs[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  37};
        vecs[4]  = '{2'b00, 32'd7,          32'd0,          32'hFFFF_FFFF,  1};
        vecs[5]  = '{2'b10, 32'd7,          32'd0,          32'd7,          1};
        vecs[6]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
        vecs[7]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
        vecs[8]  = '{2'b01, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          37};
        vecs[9]  = '{2'b11, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  37};
        vecs[10] = '{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  37};
        vecs[11] = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          37};
        vecs[12] = '{2'b00, 32'hFFFF_FFF8,  32'hFFFF_FFFE,  32'd4,          37};
        vecs[13] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          37};
        vecs[14] = '{2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  37};
        vecs[15] = '{2'b11, 32'd0,          32'd5,          32'd0,          37};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = 2'b00; dividend = 32'd0; divisor = 32'd0;
        #23;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors, issued back to back.
        for (int i = 0; i < 16; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
        end

        // Flush at cycle 20 of a DIVU 100/7, then DIVU 9/3.
        @(negedge clk);
        op = 2'b01; dividend = 32'd100; divisor = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int n = 1; n < 20; n++) @(negedge clk);
        chk("pre_flush_busy", {31'd0, in_ready}, 32'd0);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        bad = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        chk("flush_no_out_valid", bad, 32'd0);
        do_op(2'b01, 32'd9, 32'd3, res, lat);
        chk("post_flush_result", res, 32'd3);
        chk("post_flush_latency", lat, 32'd37);

        // Flush concurrent with in_valid in IDLE rejects the input.
        @(negedge clk);
        op = 2'b00; dividend = 32'd5; divisor = 32'd0; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_reject_in_ready", {31'd0, in_ready}, 32'd1);
        chk("flush_reject_out_valid", {31'd0, out_valid}, 32'd0);

        // Back-pressure: out_ready low for 5 cycles.
        out_ready = 1'b0;
        do_op(2'b01, 32'd1000, 32'd10, res, lat);
        chk("bp_latency", lat, 32'd37);
        for (int n = 0; n < 5; n++) begin
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_result", result, 32'd100);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_single_transfer", {31'd0, out_valid}, 32'd0);
        chk("bp_idle_again", {31'd0, in_ready}, 32'd1);

        // Asynchronous reset pulse mid-ITER.
        @(negedge clk);
        op = 2'b01; dividend = 32'd77; divisor = 32'd5; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int n = 1; n < 10; n++) @(negedge clk);
        chk("pre_reset_busy", {31'd0, in_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(2'b11, 32'd77, 32'd5, res, lat);
        chk("post_reset_result", res, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
